nand_logic_pipe: RTL and testbench
==================================

Name: nand_logic_pipe

Overview:
- Parametrised, registered successor to the 4-bit NAND gate.
- Computes a selectable bitwise function (NAND default) of two WIDTH-bit operands and queues results in a DEPTH-entry output FIFO.
- Uses a valid/ready handshake on both sides, and adds zero/all-ones result flags and a wrapping transaction counter.
- Sits between operand producers and downstream consumers in the gate-level demo datapath.

Parameters:
- WIDTH, 4: operand/result width in bits, 1..64.
- DEPTH, 2: output FIFO entries, power of 2, at least 2.
- CNT_W, 16: transaction counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts beat this cycle.
- op  in  3  function select, sampled with operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result at FIFO head.
- out_ready  in  1  consumer takes head this cycle.
- Y  out  WIDTH  head result.
- zero  out  1  head result all zeros.
- ones  out  1  head result all ones.
- txn_cnt  out  CNT_W  accepted beats, modulo 2^CNT_W.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: in_ready=1 (from the cycle after reset), out_valid=0, Y=0, zero=0, ones=0, txn_cnt=0. The FIFO pointers and count clear.
- Reset mid-operation: all queued results are discarded. An accept in the same cycle as rst is ignored and does not count.
- Op encoding:
  - 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT A (B ignored).
  - 7 PASS A.
- Accept: on the rising edge where in_valid && in_ready:
  - result = f(op, A, B), WIDTH bits, no carries.
  - Push {result, result==0, result=={WIDTH{1'b1}}} into the FIFO.
  - txn_cnt increments, wrapping from 2^CNT_W-1 to 0.
- Latency: a beat accepted at edge k appears on Y with out_valid=1 after edge k when the FIFO was empty (1 cycle). There is no combinational path from A/B to Y.
- Pop: on an edge where out_valid && out_ready, the head is removed.
- Flow control:
  - in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Simultaneous push and pop: allowed whenever 0 < count < DEPTH; count is unchanged and order is preserved.
  - When full, only the pop happens that cycle. in_ready rises the next cycle.
  - When empty, only the push happens. A just-pushed beat is not visible the same cycle.
- Output while empty: Y, zero and ones hold the last popped value (0 after reset) while out_valid=0. Consumers must ignore them.
- Stability: while out_valid=1 and out_ready=0, Y, zero and ones hold stable.
- Handshake rules: an upstream source must hold A, B and op stable while in_valid=1 and in_ready=0. The block does not check this.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Undefined op values: none exist; all 8 codes are legal.

Decomposition:
- Package nand_logic_pkg:
  - op encoding localparams OP_NAND..OP_PASS_A.
  - 3-bit op typedef.
  - function logic_eval(op, a, b) returning WIDTH bits.
- Sub-module sync_fifo (WIDTH+2 data bits, DEPTH):
  - synchronous reset.
  - push/pop/full/empty/count.
  - reusable elsewhere in the codebase.
- The top holds the combinational op decode, flag generation, handshake glue and txn_cnt.

Test Plan:
- Legacy NAND (WIDTH=4, op=0): A=0010,B=0010 -> Y=1101; A=0100,B=1000 -> Y=1111, ones=1; A=1100,B=1111 -> Y=0011. Each appears 1 cycle after accept; txn_cnt=3.
- All ops, A=1100, B=1010, expected Y by op:
  - op 0 -> 0111; op 1 -> 1000; op 2 -> 1110; op 3 -> 0001.
  - op 4 -> 0110; op 5 -> 1001; op 6 -> 0011; op 7 -> 1100.
  - zero=0, ones=0 throughout.
- Backpressure fill: out_ready=0, in_valid held 1 with 3 beats -> in_ready drops after 2 accepts (DEPTH=2), the third beat waits, and Y holds the first result. Then out_ready=1 -> results drain in order, the third beat is accepted the cycle after in_ready rises, and txn_cnt=3.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with varying operands -> 10 results in order, one per cycle after the first, count never exceeds 1.
- Flags: op=1, A=0000, B=1111 -> Y=0000, zero=1. op=7, A=1111 -> ones=1.
- Reset and wrap:
  - Assert rst with 2 results queued -> next cycle out_valid=0, txn_cnt=0, in_ready=1.
  - Separately, CNT_W=4 with 17 accepts -> txn_cnt=1.

Source files
------------

// File: rtl/nand_logic_pkg.sv
// rtl/nand_logic_pkg.sv - op encoding and bitwise function evaluation for nand_logic_pipe
package nand_logic_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NAND   = 3'd0;
  localparam op_t OP_AND    = 3'd1;
  localparam op_t OP_OR     = 3'd2;
  localparam op_t OP_NOR    = 3'd3;
  localparam op_t OP_XOR    = 3'd4;
  localparam op_t OP_XNOR   = 3'd5;
  localparam op_t OP_NOT_A  = 3'd6;
  localparam op_t OP_PASS_A = 3'd7;

  // Widest operand supported; callers zero-extend and keep the low WIDTH bits.
  localparam int MAX_W = 64;

  // Bitwise function of a and b; bit i of the result depends only on bit i of each operand.
  function automatic logic [MAX_W-1:0] logic_eval(op_t op, logic [MAX_W-1:0] a,
                                                  logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_NAND:  r = ~(a & b);
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NOT_A: r = ~a;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nand_logic_pipe_sync_fifo.sv
// rtl/nand_logic_pipe_sync_fifo.sv - synchronous FIFO with registered pointers and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO or a pop from an empty one is dropped rather than corrupting state.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointers and occupancy; power-of-two depth lets pointers wrap on overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless outside the live window so it is never cleared.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/nand_logic_pipe.sv
// rtl/nand_logic_pipe.sv - registered selectable bitwise gate with output FIFO, flags and txn counter
module nand_logic_pipe
  import nand_logic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int DW = WIDTH + 2;
  localparam int AW = $clog2(DEPTH);

  logic [MAX_W-1:0] eval_full;
  logic [WIDTH-1:0] result;
  logic             res_zero, res_ones;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [DW-1:0]    head;
  logic [AW:0]      fifo_count_unused;
  logic [DW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  // Evaluate the selected function at full package width, keep the low WIDTH bits and flag them.
  always_comb begin
    eval_full = logic_eval(op_t'(op), MAX_W'(A), MAX_W'(B));
    result    = eval_full[WIDTH-1:0];
    res_zero  = (result == '0);
    res_ones  = &result;
  end

  if (WIDTH < MAX_W) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^eval_full[MAX_W-1:WIDTH];
  end

  // Handshake glue: readiness depends only on registered FIFO occupancy.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({result, res_zero, res_ones}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  // Show the live head, or the last popped entry while the FIFO is empty.
  assign {Y, zero, ones} = out_valid ? head : hold_q;
  assign txn_cnt         = txn_cnt_q;

  // Capture the departing head on a pop and advance the counter on an accept.
  always_comb begin
    hold_d    = pop  ? head : hold_q;
    txn_cnt_d = push ? txn_cnt_q + 1'b1 : txn_cnt_q;
  end

  // Holding register and transaction counter; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      txn_cnt_q <= '0;
    end else begin
      hold_q    <= hold_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

endmodule

// File: tb/tb_nand_logic_pipe.sv
// tb/tb_nand_logic_pipe.sv - scoreboard bench for nand_logic_pipe against a truth-table model
module tb_nand_logic_pipe;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, zero, ones;
  logic [W-1:0] Y;
  logic [15:0]  txn_cnt;
  logic         in_ready_w, out_valid_w, zero_w, ones_w;
  logic [W-1:0] Y_w;
  logic [3:0]   txn_cnt_w;

  always #5 clk = ~clk;

  nand_logic_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .zero(zero), .ones(ones),
    .txn_cnt(txn_cnt)
  );

  nand_logic_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op(op), .A(A), .B(B),
    .out_valid(out_valid_w), .out_ready(out_ready), .Y(Y_w), .zero(zero_w), .ones(ones_w),
    .txn_cnt(txn_cnt_w)
  );

  // Truth table per op, indexed by {a_bit, b_bit}.
  logic [3:0]   tt [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                           4'b0110, 4'b1001, 4'b0011, 4'b1100};
  logic [W-1:0] ops_y [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                              4'b0110, 4'b1001, 4'b0011, 4'b1100};

  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_y;
  logic         last_zero, last_ones;
  int unsigned  acc_cnt;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           rnd_done;

  function automatic logic [W-1:0] ref_f(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[o];
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 just after the beat's accepting edge.
  task automatic send_exp(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] y);
    int guard = 0;
    op = o; A = a; B = b; in_valid = 1'b1;
    while (!in_ready) begin
      @(posedge clk); #2;
      guard++;
      if (guard > 100) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    exp_q.push_back(y);
    acc_cnt++;
    #1;
  endtask

  task automatic send(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    send_exp(o, a, b, ref_f(o, a, b));
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
    last_y = '0; last_zero = 1'b0; last_ones = 1'b0;
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); #2; guard++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results left, required 0", exp_q.size());
    end
  endtask

  // Monitor: compare DUT outputs with the scoreboard once per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",    in_ready,    exp_q.size() != D);
      check("in_ready_w",  in_ready_w,  exp_q.size() != D);
      check("out_valid",   out_valid,   exp_q.size() != 0);
      check("out_valid_w", out_valid_w, exp_q.size() != 0);
      check("txn_cnt",     txn_cnt,     acc_cnt[15:0]);
      check("txn_cnt_w",   txn_cnt_w,   acc_cnt[3:0]);
      if (exp_q.size() != 0) begin
        check("Y",      Y,      exp_q[0]);
        check("zero",   zero,   exp_q[0] == '0);
        check("ones",   ones,   &exp_q[0]);
        check("Y_w",    Y_w,    exp_q[0]);
        check("zero_w", zero_w, exp_q[0] == '0);
        if (out_ready) begin
          last_y    = exp_q[0];
          last_zero = (exp_q[0] == '0);
          last_ones = &exp_q[0];
          void'(exp_q.pop_front());
        end
      end else begin
        check("Y_hold",    Y,    last_y);
        check("zero_hold", zero, last_zero);
        check("ones_hold", ones, last_ones);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; A = '0; B = '0;
    acc_cnt = 0; last_y = '0; last_zero = 1'b0; last_ones = 1'b0; rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    @(negedge clk);
    check("reset_Y", Y, 0);
    check("reset_flags", {zero, ones}, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #2;

    // Legacy NAND vectors
    send_exp(3'd0, 4'b0010, 4'b0010, 4'b1101);
    send_exp(3'd0, 4'b0100, 4'b1000, 4'b1111);
    send_exp(3'd0, 4'b1100, 4'b1111, 4'b0011);
    idle(3);
    check("legacy_txn_cnt", txn_cnt, 3);

    // Every op on A=1100, B=1010
    for (int o = 0; o < 8; o++) send_exp(3'(o), 4'b1100, 4'b1010, ops_y[o]);
    idle(3);

    // Reset with two results queued and an offered beat during reset
    out_ready = 1'b0;
    send(3'd4, 4'b0101, 4'b0011);
    send(3'd2, 4'b1000, 4'b0001);
    in_valid = 1'b1; op = 3'd1; A = 4'hf; B = 4'hf;
    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_txn_cnt", txn_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_Y", Y, 0);
    @(posedge clk); #2;
    out_ready = 1'b1;

    // Backpressure fill then drain
    out_ready = 1'b0;
    fork
      begin
        send(3'd0, 4'b0001, 4'b0011);
        send(3'd1, 4'b0111, 4'b1110);
        send(3'd3, 4'b0100, 4'b0010);
        idle(1);
      end
      begin
        repeat (6) begin @(posedge clk); #2; end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_txn_cnt", txn_cnt, 3);

    // Streaming, consumer always ready
    for (int i = 0; i < 10; i++) send(3'($urandom_range(7)), 4'($urandom), 4'($urandom));
    idle(2);

    // Flags
    send_exp(3'd1, 4'b0000, 4'b1111, 4'b0000);
    send_exp(3'd7, 4'b1111, 4'b0110, 4'b1111);
    idle(2);

    // Counter wrap on the CNT_W=4 instance
    do_reset();
    for (int i = 0; i < 17; i++) send(3'($urandom_range(7)), 4'($urandom), 4'($urandom));
    idle(3);
    check("wrap_txn_cnt_w", txn_cnt_w, 1);
    check("wrap_txn_cnt", txn_cnt, 17);

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(3'($urandom_range(7)), 4'($urandom), 4'($urandom));
          if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(3) != 0);
          @(posedge clk); #2;
        end
      end
    join
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
